// File: rtl/fetch_ctrl_if.sv
// Instruction-bus bundle between the fetch sequencer (master) and memory (slave).
interface fetch_ctrl_if #(
  parameter int unsigned PC_W    = 64,
  parameter int unsigned INSTR_W = 32
);
  logic               ibus_valid;
  logic [PC_W-1:0]    ibus_addr;
  logic               ibus_data_ok;
  logic [INSTR_W-1:0] ibus_data;

  modport master (
    output ibus_valid,
    output ibus_addr,
    input  ibus_data_ok,
    input  ibus_data
  );

  modport slave (
    input  ibus_valid,
    input  ibus_addr,
    output ibus_data_ok,
    output ibus_data
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, keeps one instruction-bus request in
// flight, and hands fetched instructions to decode through a one-entry
// output register. Redirect takes priority over decode stall.
module fetch_ctrl #(
  parameter int unsigned     PC_W     = 64,
  parameter int unsigned     INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = 'h8000_0000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_redirect,
  input  logic [PC_W-1:0]    i_redirect_pc,
  input  logic               i_stall,
  fetch_ctrl_if.master       ibus,
  output logic               o_f_valid,
  output logic [PC_W-1:0]    o_f_pc,
  output logic [INSTR_W-1:0] o_f_instr,
  output logic [PC_W-1:0]    o_pc
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_HOLD,
    S_DRAIN
  } state_t;

  state_t             r_state;
  logic [PC_W-1:0]    r_pc;
  logic [PC_W-1:0]    r_addr;
  logic               r_ibus_valid;
  logic               r_f_valid;
  logic [PC_W-1:0]    r_f_pc;
  logic [INSTR_W-1:0] r_f_instr;

  logic [PC_W-1:0]    w_pc_inc;

  // Sequential PC increment, wraps modulo 2^PC_W.
  always_comb begin
    w_pc_inc = r_pc + PC_W'(4);
  end

  // Fetch FSM with registered bus request and output register.
  // r_ibus_valid is low in FETCH only for the first cycle after reset; that
  // cycle launches the first request (at a redirect target if one is present).
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_PC;
      r_addr       <= RESET_PC;
      r_ibus_valid <= 1'b0;
      r_f_valid    <= 1'b0;
      r_f_pc       <= '0;
      r_f_instr    <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (!r_ibus_valid) begin
            r_ibus_valid <= 1'b1;
            if (i_redirect) begin
              r_pc   <= i_redirect_pc;
              r_addr <= i_redirect_pc;
            end
          end else if (ibus.ibus_data_ok) begin
            if (i_redirect) begin
              r_pc   <= i_redirect_pc;
              r_addr <= i_redirect_pc;
            end else begin
              r_f_valid    <= 1'b1;
              r_f_pc       <= r_addr;
              r_f_instr    <= ibus.ibus_data;
              r_pc         <= w_pc_inc;
              r_ibus_valid <= 1'b0;
              r_state      <= S_HOLD;
            end
          end else if (i_redirect) begin
            r_pc    <= i_redirect_pc;
            r_state <= S_DRAIN;
          end
        end

        S_DRAIN: begin
          if (i_redirect) begin
            r_pc <= i_redirect_pc;
          end
          if (ibus.ibus_data_ok) begin
            r_addr  <= i_redirect ? i_redirect_pc : r_pc;
            r_state <= S_FETCH;
          end
        end

        S_HOLD: begin
          if (i_redirect) begin
            r_f_valid    <= 1'b0;
            r_pc         <= i_redirect_pc;
            r_addr       <= i_redirect_pc;
            r_ibus_valid <= 1'b1;
            r_state      <= S_FETCH;
          end else if (!i_stall) begin
            r_f_valid    <= 1'b0;
            r_addr       <= r_pc;
            r_ibus_valid <= 1'b1;
            r_state      <= S_FETCH;
          end
        end

        default: begin
          r_state <= S_FETCH;
        end
      endcase
    end
  end

  assign ibus.ibus_valid = r_ibus_valid;
  assign ibus.ibus_addr  = r_addr;
  assign o_f_valid       = r_f_valid;
  assign o_f_pc          = r_f_pc;
  assign o_f_instr       = r_f_instr;
  assign o_pc            = r_pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed bus/redirect/stall sequences, a transaction
// level model checked every cycle, plus literal expectations at key points.
module tb_fetch_ctrl;

  localparam int unsigned PC_W    = 64;
  localparam int unsigned INSTR_W = 32;
  localparam logic [63:0] RST_PC  = 64'h8000_0000;

  logic              clk;
  logic              rst;
  logic              redirect;
  logic [63:0]       redirect_pc;
  logic              stall;
  logic              f_valid;
  logic [63:0]       f_pc;
  logic [31:0]       f_instr;
  logic [63:0]       pc;

  fetch_ctrl_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

  fetch_ctrl #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(RST_PC)) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .i_stall       (stall),
    .ibus          (bus.master),
    .o_f_valid     (f_valid),
    .o_f_pc        (f_pc),
    .o_f_instr     (f_instr),
    .o_pc          (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // A request is either in flight or not; an in-flight request may be marked
  // "stale" (its response will be thrown away). The output slot holds at most
  // one instruction; while it is full no request is in flight.
  logic        m_req;
  logic [63:0] m_req_addr;
  logic        m_stale;
  logic [63:0] m_pc;
  logic        m_out;
  logic [63:0] m_out_pc;
  logic [31:0] m_out_instr;

  task automatic model_reset();
    m_req       = 1'b0;
    m_req_addr  = RST_PC;
    m_stale     = 1'b0;
    m_pc        = RST_PC;
    m_out       = 1'b0;
    m_out_pc    = '0;
    m_out_instr = '0;
  endtask

  task automatic issue();
    m_req      = 1'b1;
    m_req_addr = m_pc;
    m_stale    = 1'b0;
  endtask

  task automatic model_step();
    if (m_out) begin
      if (redirect) begin
        m_out = 1'b0;
        m_pc  = redirect_pc;
        issue();
      end else if (!stall) begin
        m_out = 1'b0;
        issue();
      end
    end else if (!m_req) begin
      if (redirect) m_pc = redirect_pc;
      issue();
    end else if (bus.ibus_data_ok) begin
      if (m_stale || redirect) begin
        if (redirect) m_pc = redirect_pc;
        issue();
      end else begin
        m_out       = 1'b1;
        m_out_pc    = m_req_addr;
        m_out_instr = bus.ibus_data;
        m_pc        = m_pc + 64'd4;
        m_req       = 1'b0;
      end
    end else if (redirect) begin
      m_pc    = redirect_pc;
      m_stale = 1'b1;
    end
  endtask

  // Model advance and per-cycle compare, sampled 1 time unit after the edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_reset();
    end else begin
      model_step();
      #1;
      if (!rst) begin
        check("ibus_valid", 64'(bus.ibus_valid), 64'(m_req));
        if (m_req) check("ibus_addr", bus.ibus_addr, m_req_addr);
        check("f_valid", 64'(f_valid), 64'(m_out));
        check("f_pc", f_pc, m_out_pc);
        check("f_instr", 64'(f_instr), 64'(m_out_instr));
        check("pc", pc, m_pc);
      end
    end
  end

  // Drive one cycle of inputs at a negedge and advance to the next negedge.
  task automatic cyc(input logic ok, input logic [31:0] d, input logic rd,
                     input logic [63:0] rpc, input logic st);
    bus.ibus_data_ok = ok;
    bus.ibus_data    = d;
    redirect         = rd;
    redirect_pc      = rpc;
    stall            = st;
    @(negedge clk);
  endtask

  initial begin
    rst              = 1'b1;
    redirect         = 1'b0;
    redirect_pc      = '0;
    stall            = 1'b0;
    bus.ibus_data_ok = 1'b0;
    bus.ibus_data    = '0;

    // Reset values
    #12;
    check("rst_ibus_valid", 64'(bus.ibus_valid), 64'd0);
    check("rst_ibus_addr", bus.ibus_addr, RST_PC);
    check("rst_pc", pc, RST_PC);
    check("rst_f_valid", 64'(f_valid), 64'd0);
    check("rst_f_pc", f_pc, 64'd0);
    check("rst_f_instr", 64'(f_instr), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1: three sequential fetches, single-cycle bus
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, '0, 1'b0, '0, 1'b0);
      check("t1_valid", 64'(bus.ibus_valid), 64'd1);
      check("t1_addr", bus.ibus_addr, 64'h8000_0000 + 64'(4 * k));
      cyc(1'b1, 32'h1000 + 32'(k), 1'b0, '0, 1'b0);
      check("t1_fvalid", 64'(f_valid), 64'd1);
      check("t1_fpc", f_pc, 64'h8000_0000 + 64'(4 * k));
      check("t1_finstr", 64'(f_instr), 64'h1000 + 64'(k));
      cyc(1'b0, '0, 1'b0, '0, 1'b0);
      check("t1_fvalid_drop", 64'(f_valid), 64'd0);
    end

    // 2: stall holds the output register and idles the bus
    cyc(1'b1, 32'hCAFE_0003, 1'b0, '0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, '0, 1'b0, '0, 1'b1);
      check("t2_ibus_idle", 64'(bus.ibus_valid), 64'd0);
      check("t2_fvalid", 64'(f_valid), 64'd1);
      check("t2_fpc", f_pc, 64'h8000_000C);
      check("t2_finstr", 64'(f_instr), 64'hCAFE_0003);
    end
    cyc(1'b0, '0, 1'b0, '0, 1'b0);
    check("t2_next_addr", bus.ibus_addr, 64'h8000_0010);

    // 3: redirect while request pending -> drain old request
    cyc(1'b0, '0, 1'b1, 64'h8000_0100, 1'b0);
    check("t3_pc", pc, 64'h8000_0100);
    for (int k = 0; k < 2; k++) begin
      cyc(1'b0, '0, 1'b0, '0, 1'b0);
      check("t3_addr_hold", bus.ibus_addr, 64'h8000_0010);
      check("t3_valid_hold", 64'(bus.ibus_valid), 64'd1);
    end
    cyc(1'b1, 32'hDEAD_BEEF, 1'b0, '0, 1'b0);
    check("t3_dropped", 64'(f_valid), 64'd0);
    check("t3_finstr_kept", 64'(f_instr), 64'hCAFE_0003);
    check("t3_new_addr", bus.ibus_addr, 64'h8000_0100);

    // 4: redirect coincident with data_ok
    cyc(1'b1, 32'hBAD0_0001, 1'b1, 64'h8000_0200, 1'b0);
    check("t4_fvalid", 64'(f_valid), 64'd0);
    check("t4_addr", bus.ibus_addr, 64'h8000_0200);

    // 5: redirect beats stall in HOLD
    cyc(1'b1, 32'h0000_5555, 1'b0, '0, 1'b0);
    check("t5_fpc", f_pc, 64'h8000_0200);
    cyc(1'b0, '0, 1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1, 64'h8000_0300, 1'b1);
    check("t5_fvalid", 64'(f_valid), 64'd0);
    check("t5_addr", bus.ibus_addr, 64'h8000_0300);
    check("t5_valid", 64'(bus.ibus_valid), 64'd1);

    // 6: PC wrap, then reset in the middle of a drain
    cyc(1'b1, '0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    cyc(1'b1, 32'h0000_7777, 1'b0, '0, 1'b0);
    check("t6_fpc", f_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check("t6_pc_wrap", pc, 64'd0);
    cyc(1'b0, '0, 1'b0, '0, 1'b0);
    check("t6_addr_zero", bus.ibus_addr, 64'd0);
    cyc(1'b0, '0, 1'b1, 64'h8000_0400, 1'b0);
    redirect = 1'b0;
    check("t6_drain_addr", bus.ibus_addr, 64'd0);
    check("t6_drain_pc", pc, 64'h8000_0400);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_valid", 64'(bus.ibus_valid), 64'd0);
    check("t6_rst_fvalid", 64'(f_valid), 64'd0);
    check("t6_rst_pc", pc, RST_PC);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b0, '0, 1'b0, '0, 1'b0);
    check("t6_restart_addr", bus.ibus_addr, RST_PC);
    cyc(1'b1, 32'h0000_ABCD, 1'b0, '0, 1'b0);
    check("t6_restart_fpc", f_pc, RST_PC);
    cyc(1'b0, '0, 1'b0, '0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
